// File: rtl/ppu_dequant_unpacker_pkg.sv
// Shared types and constants for the PPU dequantizing byte unpacker.
// This package holds the datapath widths, the byte offset and the FSM state encoding.
package ppu_dequant_unpacker_pkg;

  localparam int Q_W     = 8;
  localparam int DATA_W  = 32;
  localparam int SCALE_W = 12;

  // XOR with this offset turns an offset-binary byte into two's complement.
  localparam logic [Q_W-1:0] BYTE_OFFSET = 8'h80;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UNPACK = 1'b1
  } unpack_state_e;

endpackage

// File: rtl/ppu_dequant_unpacker_dequant_byte.sv
// Combinational decode of one quantized byte and its multiply by the unsigned scale.
// The worst-case product is -128 * 4095, which fits easily in the 32-bit signed result.
module dequant_byte
  import ppu_dequant_unpacker_pkg::*;
(
  input  logic [Q_W-1:0]     q_i,
  input  logic [SCALE_W-1:0] scale_i,
  output logic [DATA_W-1:0]  data_o
);

  logic [Q_W-1:0]           v;
  logic signed [DATA_W-1:0] v_ext;
  logic signed [DATA_W-1:0] s_ext;

  assign v      = q_i ^ BYTE_OFFSET;
  assign v_ext  = {{(DATA_W-Q_W){v[Q_W-1]}}, v};
  assign s_ext  = {{(DATA_W-SCALE_W){1'b0}}, scale_i};
  assign data_o = v_ext * s_ext;

endmodule

// File: rtl/ppu_dequant_unpacker.sv
// Unpacks a packed word of quantized bytes into scaled signed elements, one per output load.
// Byte 0 of an accepted word is loaded straight from the input so it appears on the next cycle.
module ppu_dequant_unpacker
  import ppu_dequant_unpacker_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_bytes_m1,
  input  logic             in_last,
  input  logic [11:0]      scaling_factor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  input  logic             clr_count,
  output logic [CNT_W-1:0] elem_count
);

  // Both ports use valid/ready: a transfer happens on the rising edge where valid and
  // ready are both 1; a valid output holds its data stable until it is taken.

  unpack_state_e         state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            m1_q, m1_d;
  logic                  last_q, last_d;
  logic [SCALE_W-1:0]    scale_q, scale_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  out_free;
  logic                  load;
  logic                  load_last_byte;
  logic                  load_tile_last;
  logic [Q_W-1:0]        cur_byte;
  logic [Q_W-1:0]        dq_byte;
  logic [SCALE_W-1:0]    dq_scale;
  logic [DATA_W-1:0]     dq_data;

  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (idx_q == 2'(b)) cur_byte = word_q[b*Q_W +: Q_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    word_d         = word_q;
    m1_d           = m1_q;
    last_d         = last_q;
    scale_d        = scale_q;
    load           = 1'b0;
    load_last_byte = 1'b0;
    load_tile_last = last_q;
    dq_byte        = cur_byte;
    dq_scale       = scale_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d         = in_data;
          m1_d           = in_bytes_m1;
          last_d         = in_last;
          scale_d        = scaling_factor;
          dq_byte        = in_data[Q_W-1:0];
          dq_scale       = scaling_factor;
          load_tile_last = in_last;
          if (out_free) begin
            // Byte 0 goes out on the accepting edge; a one-byte word is then already done.
            load           = 1'b1;
            load_last_byte = (in_bytes_m1 == 2'd0);
            if (in_bytes_m1 != 2'd0) begin
              state_d = ST_UNPACK;
              idx_d   = 2'd1;
            end
          end else begin
            state_d = ST_UNPACK;
            idx_d   = 2'd0;
          end
        end
      end
      ST_UNPACK: begin
        if (out_free) begin
          load           = 1'b1;
          load_last_byte = (idx_q == m1_q);
          if (idx_q == m1_q) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dequant_byte u_dequant_byte (
    .q_i     (dq_byte),
    .scale_i (dq_scale),
    .data_o  (dq_data)
  );

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = dq_data;
      out_last_d  = load_last_byte && load_tile_last;
    end
    cnt_d = cnt_q;
    if (clr_count)                     cnt_d = '0;
    else if (out_valid_q && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      m1_q        <= '0;
      last_q      <= 1'b0;
      scale_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      m1_q        <= m1_d;
      last_q      <= last_d;
      scale_q     <= scale_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign elem_count = cnt_q;

endmodule

// File: tb/tb_ppu_dequant_unpacker.sv
// Directed bench for ppu_dequant_unpacker: hand-computed elements in an expected queue,
// checked at every output handshake, plus timing, stall, reset and counter checks.
module tb_ppu_dequant_unpacker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_bytes_m1;
  logic        in_last;
  logic [11:0] scaling_factor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        clr_count;
  logic [15:0] elem_count;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b1;
  logic [32:0] exp_q[$];

  ppu_dequant_unpacker #(.BYTES_PER_WORD(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_bytes_m1    (in_bytes_m1),
    .in_last        (in_last),
    .scaling_factor (scaling_factor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .clr_count      (clr_count),
    .elem_count     (elem_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted element is {out_last, out_data}
  always @(negedge clk) begin
    if (!rst && mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
      end else begin
        check("out_elem", {31'd0, out_last, out_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic last, input logic [31:0] d);
    exp_q.push_back({last, d});
  endtask

  // Drives one word for one accepting edge; returns one cycle after acceptance.
  task automatic send_word(input logic [31:0] d, input logic [1:0] m1, input logic l,
                           input logic [11:0] s);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_valid       = 1'b1;
    in_data        = d;
    in_bytes_m1    = m1;
    in_last        = l;
    scaling_factor = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((out_valid || exp_q.size() != 0) && g < 50) begin
      tick();
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int hs;
    int acc;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bytes_m1 = '0; in_last = 1'b0;
    scaling_factor = '0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_elem_count", {48'd0, elem_count}, 64'd0);

    // 4-byte word, cycle-exact: elements in N+1..N+4, in_ready back in N+4
    push(0, 32'd128); push(0, 32'd254); push(0, 32'd0); push(0, 32'd2);
    send_word(32'h8180FFC0, 2'd3, 1'b0, 12'd2);
    check("t1_n1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_n1_data", {32'd0, out_data}, 64'd128);
    check("t1_n1_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("t1_n2_data", {32'd0, out_data}, 64'd254);
    tick();
    check("t1_n3_data", {32'd0, out_data}, 64'd0);
    check("t1_n3_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("t1_n4_data", {32'd0, out_data}, 64'd2);
    check("t1_n4_in_ready", {63'd0, in_ready}, 64'd1);
    drain();

    // single byte 0xC5: 0x45 = 69, times 3 = 207, marked last
    push(1, 32'd207);
    send_word(32'h000000C5, 2'd0, 1'b1, 12'd3);
    check("t2_last", {63'd0, out_last}, 64'd1);
    drain();

    // most negative byte with the largest scale
    push(0, 32'hFFF80080);
    send_word(32'h00000000, 2'd0, 1'b0, 12'd4095);
    drain();

    // zero scale still emits four zero elements, last on the fourth
    push(0, 32'd0); push(0, 32'd0); push(0, 32'd0); push(1, 32'd0);
    send_word(32'h12345678, 2'd3, 1'b1, 12'd0);
    drain();

    // two valid bytes: 0x01 -> -127*5, 0x7F -> -1*5
    push(0, 32'hFFFFFD85); push(0, 32'hFFFFFFFB);
    send_word(32'hAAAA7F01, 2'd1, 1'b0, 12'd5);
    drain();

    // three valid bytes with last: 0x40 -> -64, 0xFF -> 127, 0x00 -> -128
    push(0, 32'hFFFFFFC0); push(0, 32'h0000007F); push(1, 32'hFFFFFF80);
    send_word(32'h5500FF40, 2'd2, 1'b1, 12'd1);
    drain();

    // consumer stalls three cycles after the first element
    out_ready = 1'b0;
    push(0, 32'd128); push(0, 32'd254); push(0, 32'd0); push(0, 32'd2);
    send_word(32'h8180FFC0, 2'd3, 1'b0, 12'd2);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_data", {32'd0, out_data}, 64'd128);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    drain();

    // second word accepted while the first word's element is still stalled
    out_ready = 1'b0;
    push(0, 32'd64); push(0, 32'd1);
    send_word(32'h000000C0, 2'd0, 1'b0, 12'd1);
    send_word(32'h00000081, 2'd0, 1'b0, 12'd1);
    check("b2b_in_ready", {63'd0, in_ready}, 64'd0);
    check("b2b_hold_data", {32'd0, out_data}, 64'd64);
    out_ready = 1'b1;
    drain();
    check("count_21", {48'd0, elem_count}, 64'd21);

    // clear in the same cycle as a handshake
    push(0, 32'd128); push(0, 32'd254); push(0, 32'd0); push(0, 32'd2);
    send_word(32'h8180FFC0, 2'd3, 1'b0, 12'd2);
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_wins", {48'd0, elem_count}, 64'd0);
    drain();
    check("count_after_clr", {48'd0, elem_count}, 64'd2);

    // reset while the second byte is on the output
    push(0, 32'hFFFFFF81);
    send_word(32'h04030201, 2'd3, 1'b0, 12'd1);
    tick();
    check("rstmid_byte1", {32'd0, out_data}, 64'hFFFFFF82);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstmid_elem_count", {48'd0, elem_count}, 64'd0);
    check("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("rstmid_no_emit", {63'd0, out_valid}, 64'd0);
    push(0, 32'd128); push(0, 32'd254); push(0, 32'd0); push(0, 32'd2);
    send_word(32'h8180FFC0, 2'd3, 1'b0, 12'd2);
    check("post_rst_byte0", {32'd0, out_data}, 64'd128);
    drain();
    check("post_rst_count", {48'd0, elem_count}, 64'd4);

    // 65536 handshakes wrap the 16-bit counter back to zero
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("wrap_start", {48'd0, elem_count}, 64'd0);
    mon_en = 1'b0;
    in_data = 32'h80808080; in_bytes_m1 = 2'd3; in_last = 1'b0; scaling_factor = 12'd0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    hs = 0; acc = 0; guard = 0;
    while (hs < 65536 && guard < 70000) begin
      if (out_valid && out_ready) hs++;
      if (in_valid && in_ready) acc++;
      tick();
      guard++;
      if (acc == 16384) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("wrap_handshakes", 64'(hs), 64'd65536);
    check("wrap_count", {48'd0, elem_count}, 64'd0);
    mon_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
